cpu_trace_buffer: RTL

CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

---
 rtl/cpu_trace_buffer_if.sv | 40 ++++
 rtl/cpu_trace_buffer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/cpu_trace_buffer_if.sv
// CPU trace buffer bus: capture inputs, control, readout and status.
// ENTRY_W follows TRACE_TIMESTAMP_EN (56 with timestamp, 40 without).
interface cpu_trace_buffer_if #(
    parameter int unsigned ADDR_W = 6
);
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = 56;
`else
    localparam int unsigned ENTRY_W = 40;
`endif

    logic               iArm;
    logic [1:0]         iTrigMode;
    logic [15:0]        iTrigAddr;
    logic               iEof;
    logic [15:0]        iPc;
    logic [7:0]         iA;
    logic [7:0]         iFlags;
    logic               iMemWe;
    logic [15:0]        iMemAddr;
    logic [7:0]         iMemData;
    logic               iRdReq;
    logic               oRdValid;
    logic [ENTRY_W-1:0] oRdData;
    logic [1:0]         oState;
    logic [ADDR_W:0]    oCount;
    logic               oDropped;

    modport master (
        output iArm, iTrigMode, iTrigAddr, iEof, iPc, iA, iFlags,
        output iMemWe, iMemAddr, iMemData, iRdReq,
        input  oRdValid, oRdData, oState, oCount, oDropped
    );

    modport slave (
        input  iArm, iTrigMode, iTrigAddr, iEof, iPc, iA, iFlags,
        input  iMemWe, iMemAddr, iMemData, iRdReq,
        output oRdValid, oRdData, oState, oCount, oDropped
    );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Circular CPU trace capture with trigger and post-trigger window, drained oldest first.
// TRACE_TIMESTAMP_EN appends a 16-bit free-running cycle count to every entry.
module cpu_trace_buffer #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned POST_TRIG = 16
) (
    input logic               iClock,
    input logic               iReset,
    cpu_trace_buffer_if.slave bus
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam int unsigned PostW = $clog2(POST_TRIG + 2);
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = 56;
`else
    localparam int unsigned ENTRY_W = 40;
`endif
    localparam logic [ADDR_W:0] CountFull = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {StIdle, StArmed, StPost, StDone} stateE;

    stateE               stateQ, stateD;
    logic [ADDR_W-1:0]   wrPtrQ, rdPtrQ;
    logic [ADDR_W:0]     countQ;
    logic [PostW-1:0]    postCntQ;
    logic                droppedQ;
    logic                rdValidQ;
    logic [ENTRY_W-1:0]  rdDataQ;
    logic [ENTRY_W-1:0]  mem [Depth];

    logic                evt, trigHit, storeEn;
    logic [39:0]         baseEntry;
    logic [ENTRY_W-1:0]  entry;

    assign evt = bus.iEof | bus.iMemWe;
    // A write wins over a coincident instruction end.
    assign baseEntry = bus.iMemWe ? {1'b1, 7'b0, bus.iMemAddr, bus.iMemData, 8'h00}
                                  : {1'b0, 7'b0, bus.iPc, bus.iA, bus.iFlags};

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] stampQ;
    always_ff @(posedge iClock) begin
        if (iReset) stampQ <= '0;
        else        stampQ <= stampQ + 16'd1;
    end
    assign entry = {baseEntry, stampQ};
`else
    assign entry = baseEntry;
`endif

    always_comb begin
        trigHit = 1'b0;
        unique case (bus.iTrigMode)
            2'd0:    trigHit = evt;
            2'd1:    trigHit = bus.iEof && (bus.iPc == bus.iTrigAddr);
            2'd2:    trigHit = bus.iMemWe && (bus.iMemAddr == bus.iTrigAddr);
            default: trigHit = 1'b0;
        endcase
    end

    always_comb begin
        stateD  = stateQ;
        storeEn = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (bus.iArm) stateD = StArmed;
            end
            StArmed: begin
                storeEn = evt;
                if (trigHit) stateD = StPost;
            end
            StPost: begin
                if (postCntQ == '0) begin
                    stateD = StDone;
                end else begin
                    storeEn = evt;
                    if (evt && postCntQ == PostW'(1)) stateD = StDone;
                end
            end
            StDone: begin
                // Leave once the response that emptied the buffer has been presented.
                if (countQ == '0 && rdValidQ) stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            stateQ   <= StIdle;
            wrPtrQ   <= '0;
            rdPtrQ   <= '0;
            countQ   <= '0;
            postCntQ <= '0;
            droppedQ <= 1'b0;
            rdValidQ <= 1'b0;
            rdDataQ  <= '0;
        end else begin
            stateQ   <= stateD;
            rdValidQ <= 1'b0;
            if (stateQ == StIdle && bus.iArm) begin
                wrPtrQ   <= '0;
                rdPtrQ   <= '0;
                countQ   <= '0;
                droppedQ <= 1'b0;
            end
            if (storeEn) begin
                wrPtrQ <= wrPtrQ + 1'b1;
                if (countQ == CountFull) rdPtrQ <= rdPtrQ + 1'b1;
                else                     countQ <= countQ + 1'b1;
                if (bus.iEof && bus.iMemWe) droppedQ <= 1'b1;
            end
            if (stateQ == StArmed && trigHit) begin
                postCntQ <= PostW'(POST_TRIG);
            end else if (stateQ == StPost && storeEn) begin
                postCntQ <= postCntQ - 1'b1;
            end
            if (stateQ == StDone && bus.iRdReq && countQ != '0) begin
                rdValidQ <= 1'b1;
                rdDataQ  <= mem[rdPtrQ];
                rdPtrQ   <= rdPtrQ + 1'b1;
                countQ   <= countQ - 1'b1;
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (storeEn && !iReset) mem[wrPtrQ] <= entry;
    end

    assign bus.oState   = stateQ;
    assign bus.oCount   = countQ;
    assign bus.oDropped = droppedQ;
    assign bus.oRdValid = rdValidQ;
    assign bus.oRdData  = rdDataQ;
endmodule
